// File: rtl/parity_pkg.sv
// Shared types for the even-parity serializer.
// FSM state encoding and default payload width.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } ser_state_t;

  localparam int DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first.
// Ports: clk, reset (async low), load, shift, d[DATA_BITS], lsb.
module piso_shift_reg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] d,
  output logic                 lsb
);

  logic [DATA_BITS-1:0] q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  assign lsb = q[0];

endmodule

// File: rtl/even_parity_serializer.sv
// Valid/ready word in, LSB-first serial frame out + even parity bit.
// Ports: clk, reset (async low), data_in, data_valid, data_ready,
//   serial_bit, bit_valid, frame_start, frame_end, busy.
// Optional: EVEN_PARITY_SERIALIZER_INJECT_EN adds inject_err, which
//   inverts the parity bit of the accepted word's frame.
module even_parity_serializer
  import parity_pkg::*;
#(
  parameter  int DATA_BITS = DEFAULT_DATA_BITS,
  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
`ifdef EVEN_PARITY_SERIALIZER_INJECT_EN
  input  logic                 inject_err,
`endif
  output logic                 data_ready,
  output logic                 serial_bit,
  output logic                 bit_valid,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BITS - 1);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             par;
  logic             par_out;
  logic             hs;
  logic             last;
  logic             sh_lsb;

  // Ready is a pure state decode, so the handshake
  // never depends on a combinational output path.
  assign hs   = data_valid && (state == IDLE);
  assign last = (cnt == LAST);

  piso_shift_reg #(
    .DATA_BITS(DATA_BITS)
  ) u_shreg (
    .clk  (clk),
    .reset(reset),
    .load (hs),
    .shift(state == SHIFT),
    .d    (data_in),
    .lsb  (sh_lsb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = PARITY;
      PARITY:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      par <= 1'b0;
    end else if (hs) begin
      cnt <= '0;
      par <= ^data_in;
    end else if (state == SHIFT && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef EVEN_PARITY_SERIALIZER_INJECT_EN
  logic inj;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj <= 1'b0;
    end else if (hs) begin
      inj <= inject_err;
    end else if (state == PARITY) begin
      inj <= 1'b0;
    end
  end

  assign par_out = par ^ inj;
`else
  assign par_out = par;
`endif

  always_comb begin
    data_ready  = 1'b0;
    serial_bit  = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    busy        = 1'b1;
    unique case (1'b1)
      (state == SHIFT): begin
        bit_valid   = 1'b1;
        serial_bit  = sh_lsb;
        frame_start = (cnt == '0);
      end
      (state == PARITY): begin
        bit_valid  = 1'b1;
        serial_bit = par_out;
        frame_end  = 1'b1;
      end
      default: begin
        data_ready = 1'b1;
        busy       = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_even_parity_serializer.sv
// Bench for even_parity_serializer: table of words plus
// hand-written back-to-back, ignore-while-busy and reset-abort runs.
module tb_even_parity_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_ready;
  logic       serial_bit;
  logic       bit_valid;
  logic       frame_start;
  logic       frame_end;
  logic       busy;

  even_parity_serializer #(
    .DATA_BITS(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
`ifdef EVEN_PARITY_SERIALIZER_INJECT_EN
    .inject_err (1'b0),
`endif
    .data_ready (data_ready),
    .serial_bit (serial_bit),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard: model frame {^d, d} pushed at handshake,
  // popped and compared bit by bit as the stream appears.
  logic [8:0] exp_q[$];
  int         hs_q[$];
  int         hs_log[$];
  logic [8:0] got_q[$];
  logic [8:0] cur = '0;
  logic [8:0] col = '0;
  int         idx = 0;
  int         ones = 0;
  bit         after_end = 0;
  int         fe_count = 0;

  always @(negedge clk) begin
    if (!reset) begin
      idx = 0;
      exp_q.delete();
      hs_q.delete();
      after_end = 0;
    end else begin
      check("ready_vs_busy", data_ready, !busy);
      if (after_end) begin
        check("idle_gap_ready", data_ready, 1);
        check("idle_gap_bit_valid", bit_valid, 0);
        after_end = 0;
      end
      if (bit_valid) begin
        if (idx == 0) begin
          col = '0;
          ones = 0;
          if (exp_q.size() == 0) begin
            total++;
            cur = '0;
            $display("FAIL spurious_frame: bit_valid=1 with no word");
          end else begin
            cur = exp_q.pop_front();
            check("first_bit_latency", cyc - hs_q.pop_front(), 1);
          end
        end
        check("serial_bit", serial_bit, cur[idx]);
        check("frame_start", frame_start, idx == 0);
        check("frame_end", frame_end, idx == 8);
        check("busy_in_frame", busy, 1);
        col[idx] = serial_bit;
        ones += int'(serial_bit);
        idx++;
        if (idx == 9) begin
          check("checker_even", ones % 2, 0);
          got_q.push_back(col);
          idx = 0;
          after_end = 1;
        end
      end else begin
        check("idle_markers", {frame_start, frame_end}, 0);
      end
      if (frame_end) fe_count++;
      if (data_valid && data_ready) begin
        exp_q.push_back({^data_in, data_in});
        hs_q.push_back(cyc);
        hs_log.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    bit ok = 0;
    data_in = d;
    data_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (data_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!hold) data_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL handshake_timeout: word %0h not accepted", d);
    end
  endtask

  task automatic wait_frames(input int n);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (got_q.size() >= n) ok = 1;
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      total++;
      $display("FAIL frame_timeout: got %0d frames need %0d",
               got_q.size(), n);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [8:0] frame;
    bit         pulse;
  } vec_t;

  vec_t vt[3];

  initial begin
    int n0;
    int h0;
    int f0;
    bit ok;

    vt[0] = '{8'hA5, 9'h0A5, 1'b0};
    vt[1] = '{8'h07, 9'h107, 1'b0};
    vt[2] = '{8'h3C, 9'h03C, 1'b1};

    #2 reset = 1'b0;
    #1;
    check("rst_ready", data_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_serial_bit", serial_bit, 0);
    check("rst_frame_end", frame_end, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      n0 = got_q.size();
      h0 = hs_log.size();
      send(vt[i].data, 0);
      if (vt[i].pulse) begin
        repeat (3) @(posedge clk);
        #1;
        data_in = 8'h55;
        data_valid = 1'b1;
        @(posedge clk);
        #1 data_valid = 1'b0;
      end
      wait_frames(n0 + 1);
      if (got_q.size() > n0)
        check($sformatf("frame_%0h", vt[i].data),
              got_q[n0], vt[i].frame);
      check($sformatf("accepts_%0h", vt[i].data),
            hs_log.size() - h0, 1);
      repeat (2) @(posedge clk);
      #1;
    end

    n0 = got_q.size();
    h0 = hs_log.size();
    send(8'h01, 1);
    data_in = 8'hFF;
    send(8'hFF, 0);
    wait_frames(n0 + 2);
    if (hs_log.size() >= h0 + 2)
      check("b2b_period", hs_log[h0+1] - hs_log[h0], 10);
    if (got_q.size() >= n0 + 2) begin
      check("b2b_frame_01", got_q[n0], 9'h101);
      check("b2b_frame_ff", got_q[n0+1], 9'h0FF);
    end
    repeat (2) @(posedge clk);
    #1;

    n0 = got_q.size();
    f0 = fe_count;
    send(8'hF0, 0);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (idx == 5) ok = 1;
    end
    if (!ok) begin
      total++;
      $display("FAIL abort_reach_bit4: idx %0d", idx);
    end
    check("bit4_before_abort", serial_bit, 1);
    reset = 1'b0;
    #1;
    check("abort_ready", data_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_bit_valid", bit_valid, 0);
    check("abort_serial_bit", serial_bit, 0);
    check("abort_frame_end", frame_end, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("abort_no_frame", got_q.size() - n0, 0);
    check("abort_no_frame_end", fe_count - f0, 0);
    repeat (2) @(posedge clk);
    #1;
    send(8'h0F, 0);
    wait_frames(n0 + 1);
    if (got_q.size() > n0)
      check("frame_0f_after_abort", got_q[n0], 9'h00F);
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/even_parity_serializer.md
Name: even_parity_serializer

Overview:
- Upstream transmit stage for the even-parity checker FSM.
- Accepts a parallel word through a valid/ready handshake and emits it as a serial stream, LSB first.
- Appends one even-parity bit, so every frame carries an even number of 1s.
- Frame markers let the downstream checker be re-armed per frame and sampled at frame end.

Parameters:
- DATA_BITS, 8, payload width; legal range 1..32.
- CNT_W, (DATA_BITS>1 ? $clog2(DATA_BITS) : 1), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
- data_in  input  DATA_BITS  parallel payload; sampled only on handshake
- data_valid  input  1  producer offers data_in
- data_ready  output  1  block can accept a word
- serial_bit  output  1  current serial bit
- bit_valid  output  1  serial_bit is meaningful this cycle
- frame_start  output  1  high with the first payload bit (bit 0)
- frame_end  output  1  high with the parity bit
- busy  output  1  frame in progress (state != IDLE)

Behaviour:
- Moore FSM with states IDLE, SHIFT, PARITY. All outputs are decoded from registered state; no input-to-output combinational path.
- Reset (asynchronous, reset==0):
  - state=IDLE, shift register=0, parity register=0, counter=0.
  - Outputs: data_ready=1, serial_bit=0, bit_valid=0, frame_start=0, frame_end=0, busy=0.
- IDLE:
  - data_ready=1, bit_valid=0, serial_bit=0.
  - On a clock edge with data_valid&&data_ready: shreg<=data_in, par<=^data_in, cnt<=0, state<=SHIFT.
  - Without data_valid, remain in IDLE.
- SHIFT:
  - data_ready=0, bit_valid=1, serial_bit=shreg[0], frame_start=(cnt==0).
  - Each edge: shreg shifts right with 0 fill; cnt increments.
  - When cnt==DATA_BITS-1, state<=PARITY instead of incrementing.
  - With DATA_BITS=1, SHIFT lasts exactly one cycle.
- PARITY:
  - data_ready=0, bit_valid=1, serial_bit=par, frame_end=1. Next edge: state<=IDLE.
- Timing:
  - Handshake edge to first serial bit: 1 cycle.
  - Frame length: DATA_BITS+1 valid cycles.
  - Word period: DATA_BITS+2 cycles, since one mandatory IDLE cycle follows each frame.
- data_valid while busy is ignored; data_in may change freely and is not re-sampled.
- A word held valid across the end of a frame is accepted in the IDLE cycle after frame_end.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). No parity bit is emitted. The next frame restarts from bit 0.
- Invariant: across each frame, the count of 1s on serial_bit where bit_valid=1 is even (absent injection).

Optional Feature:
- Macro: EVEN_PARITY_SERIALIZER_INJECT_EN.
- When defined:
  - Adds input port inject_err (1 bit), sampled at the handshake edge into an inject register.
  - If set, the PARITY cycle outputs ~par, producing a deliberately odd frame to exercise the downstream error flag.
  - The inject register clears on reset and on leaving PARITY.
- When undefined: the port and register do not exist, and the parity bit is always ^data_in.

Decomposition:
- Shared package parity_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, PARITY} ser_state_t.
  - Constant DEFAULT_DATA_BITS=8.
- Top block holds the FSM, counter, and handshake logic.
- One natural sub-module, piso_shift_reg: parameterised DATA_BITS shift register with load/shift enables and LSB tap.

Test Plan:
- Reset with reset=0 for 2 cycles, then release:
  - Required: data_ready=1, busy=0, bit_valid=0, serial_bit=0 immediately on assertion, without waiting for a clock edge.
- data_in=8'hA5, data_valid for 1 cycle:
  - serial_bit over 9 valid cycles = 1,0,1,0,0,1,0,1 then parity 0.
  - frame_start on cycle 1, frame_end on cycle 9, data_ready=1 on cycle 10.
- data_in=8'h07:
  - Bits 1,1,1,0,0,0,0,0 then parity 1.
  - Driving a checker model with the stream gives even parity at frame_end.
- data_valid held high with 8'h01 then 8'hFF:
  - Second word accepted exactly 10 cycles after the first.
  - 8'hFF parity bit = 0; no overlap between frames.
- data_valid pulsed mid-frame with 8'h55 while sending 8'h3C:
  - Ignored; the 8'h3C frame completes unchanged.
- Reset pulsed during bit 4 of 8'hF0:
  - Outputs drop to reset values asynchronously; no frame_end.
  - A subsequent 8'h0F frame emits cleanly from bit 0 with parity 0.
